// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register map, register-select decode and APB constants for apb_gpio_ctrl
package gpio_pkg;

    localparam logic [7:0] OFF_DATA_OUT   = 8'h00;
    localparam logic [7:0] OFF_DIR        = 8'h04;
    localparam logic [7:0] OFF_DATA_IN    = 8'h08;
    localparam logic [7:0] OFF_INT_EN     = 8'h0C;
    localparam logic [7:0] OFF_INT_TYPE   = 8'h10;
    localparam logic [7:0] OFF_INT_POL    = 8'h14;
    localparam logic [7:0] OFF_INT_STATUS = 8'h18;
    localparam logic [7:0] OFF_OUT_SET    = 8'h1C;
    localparam logic [7:0] OFF_OUT_CLR    = 8'h20;

    localparam logic PREADY_VAL = 1'b1;

    typedef enum logic [3:0] {
        SEL_DATA_OUT,
        SEL_DIR,
        SEL_DATA_IN,
        SEL_INT_EN,
        SEL_INT_TYPE,
        SEL_INT_POL,
        SEL_INT_STATUS,
        SEL_OUT_SET,
        SEL_OUT_CLR,
        SEL_NONE
    } reg_sel_e;

    // Unaligned offsets fall through to SEL_NONE, which the top treats as an error.
    function automatic reg_sel_e decode_sel(input logic [7:0] off);
        case (off)
            OFF_DATA_OUT:   return SEL_DATA_OUT;
            OFF_DIR:        return SEL_DIR;
            OFF_DATA_IN:    return SEL_DATA_IN;
            OFF_INT_EN:     return SEL_INT_EN;
            OFF_INT_TYPE:   return SEL_INT_TYPE;
            OFF_INT_POL:    return SEL_INT_POL;
            OFF_INT_STATUS: return SEL_INT_STATUS;
            OFF_OUT_SET:    return SEL_OUT_SET;
            OFF_OUT_CLR:    return SEL_OUT_CLR;
            default:        return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - pin synchroniser, edge history, prime counter and per-pin event detection
module gpio_sync_edge
    import gpio_pkg::*;
#(
    parameter int NUM_PINS    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_PINS-1:0] pins_i,
    input  logic [NUM_PINS-1:0] int_type_i,
    input  logic [NUM_PINS-1:0] int_pol_i,
    output logic [NUM_PINS-1:0] sync_o,
    output logic [NUM_PINS-1:0] event_o
);

    localparam int PRIME_MAX = SYNC_STAGES + 1;
    localparam int CNT_W     = $clog2(PRIME_MAX + 1);

    logic [NUM_PINS-1:0] stage_q [SYNC_STAGES];
    logic [NUM_PINS-1:0] prev_q;
    logic [CNT_W-1:0]    prime_q;
    logic [CNT_W-1:0]    prime_d;
    logic                primed;
    logic [NUM_PINS-1:0] edge_ev;
    logic [NUM_PINS-1:0] level_ev;

    assign primed  = (prime_q == CNT_W'(PRIME_MAX));
    assign prime_d = primed ? prime_q : prime_q + CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                stage_q[s] <= '0;
            end
            prev_q  <= '0;
            prime_q <= '0;
        end else begin
            stage_q[0] <= pins_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
            prev_q  <= stage_q[SYNC_STAGES-1];
            prime_q <= prime_d;
        end
    end

    assign sync_o = stage_q[SYNC_STAGES-1];

    // Edges are masked until the synchroniser and history flop hold real pin values.
    assign edge_ev  = (int_pol_i & sync_o & ~prev_q) | (~int_pol_i & ~sync_o & prev_q);
    assign level_ev = (int_pol_i & sync_o) | (~int_pol_i & ~sync_o);
    assign event_o  = (int_type_i & edge_ev & {NUM_PINS{primed}}) | (~int_type_i & level_ev);

endmodule

// File: rtl/apb_gpio_ctrl.sv
// rtl/apb_gpio_ctrl.sv - APB GPIO controller: register file, atomic set/clear, W1C status and irq
module apb_gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int NUM_PINS    = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSELx,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    input  logic [NUM_PINS-1:0]     gpio_in,
    output logic [NUM_PINS-1:0]     gpio_out,
    output logic [NUM_PINS-1:0]     gpio_oe,
    output logic                    irq
);

    logic                  access;
    logic                  err;
    logic                  wr_en;
    reg_sel_e              sel;
    logic [DATA_WIDTH-1:0] byte_mask;
    logic [NUM_PINS-1:0]   keep;
    logic [NUM_PINS-1:0]   wbits;
    logic [NUM_PINS-1:0]   w1c;
    logic [NUM_PINS-1:0]   sync_pins;
    logic [NUM_PINS-1:0]   events;
    logic [NUM_PINS-1:0]   rd_pins;

    logic [NUM_PINS-1:0] data_out_q, data_out_d;
    logic [NUM_PINS-1:0] dir_q, dir_d;
    logic [NUM_PINS-1:0] int_en_q, int_en_d;
    logic [NUM_PINS-1:0] int_type_q, int_type_d;
    logic [NUM_PINS-1:0] int_pol_q, int_pol_d;
    logic [NUM_PINS-1:0] int_status_q, int_status_d;
    logic                irq_q, irq_d;

    gpio_sync_edge #(
        .NUM_PINS    (NUM_PINS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_i      (PCLK),
        .rst_i      (PRESET),
        .pins_i     (gpio_in),
        .int_type_i (int_type_q),
        .int_pol_i  (int_pol_q),
        .sync_o     (sync_pins),
        .event_o    (events)
    );

    assign access = PSELx & PENABLE;
    assign sel    = (PADDR <= ADDR_WIDTH'(OFF_OUT_CLR)) ? decode_sel(PADDR[7:0]) : SEL_NONE;
    assign err    = access & ((sel == SEL_NONE) | (PWRITE & (sel == SEL_DATA_IN)));
    assign wr_en  = access & PWRITE & ~err;

    always_comb begin
        byte_mask = '0;
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            byte_mask[8*i +: 8] = {8{PSTRB[i]}};
        end
    end

    assign keep  = byte_mask[NUM_PINS-1:0];
    assign wbits = PWDATA[NUM_PINS-1:0] & keep;

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        int_en_d   = int_en_q;
        int_type_d = int_type_q;
        int_pol_d  = int_pol_q;
        w1c        = '0;
        if (wr_en) begin
            case (sel)
                SEL_DATA_OUT:   data_out_d = (data_out_q & ~keep) | wbits;
                SEL_DIR:        dir_d      = (dir_q & ~keep) | wbits;
                SEL_INT_EN:     int_en_d   = (int_en_q & ~keep) | wbits;
                SEL_INT_TYPE:   int_type_d = (int_type_q & ~keep) | wbits;
                SEL_INT_POL:    int_pol_d  = (int_pol_q & ~keep) | wbits;
                SEL_INT_STATUS: w1c        = wbits;
                SEL_OUT_SET:    data_out_d = data_out_q | wbits;
                SEL_OUT_CLR:    data_out_d = data_out_q & ~wbits;
                default:        ;
            endcase
        end
        // A fresh event beats a simultaneous W1C of the same bit.
        int_status_d = (int_status_q & ~w1c) | events;
        irq_d        = |(int_status_q & int_en_q);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            data_out_q   <= '0;
            dir_q        <= '0;
            int_en_q     <= '0;
            int_type_q   <= '0;
            int_pol_q    <= '0;
            int_status_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            dir_q        <= dir_d;
            int_en_q     <= int_en_d;
            int_type_q   <= int_type_d;
            int_pol_q    <= int_pol_d;
            int_status_q <= int_status_d;
            irq_q        <= irq_d;
        end
    end

    always_comb begin
        rd_pins = '0;
        case (sel)
            SEL_DATA_OUT:   rd_pins = data_out_q;
            SEL_DIR:        rd_pins = dir_q;
            SEL_DATA_IN:    rd_pins = sync_pins;
            SEL_INT_EN:     rd_pins = int_en_q;
            SEL_INT_TYPE:   rd_pins = int_type_q;
            SEL_INT_POL:    rd_pins = int_pol_q;
            SEL_INT_STATUS: rd_pins = int_status_q;
            default:        rd_pins = '0;
        endcase
        PRDATA = '0;
        if (access && !err) begin
            PRDATA[NUM_PINS-1:0] = rd_pins;
        end
    end

    assign PSLVERR  = err;
    assign PREADY   = PREADY_VAL;
    assign gpio_out = data_out_q;
    assign gpio_oe  = dir_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_apb_gpio_ctrl.sv
// tb/tb_apb_gpio_ctrl.sv - directed scoreboard bench for apb_gpio_ctrl
module tb_apb_gpio_ctrl;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oe;
    logic        irq;

    apb_gpio_ctrl #(
        .NUM_PINS    (32),
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (8),
        .SYNC_STAGES (2)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PSELx    (PSELx),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that ends the access.
    task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input bit chk, input logic [31:0] exp_rd,
                       input logic exp_err, input string tag);
        exp_t e;
        if (chk) begin
            e.tag   = tag;
            e.rdata = exp_rd;
            e.err   = exp_err;
            sb_q.push_back(e);
        end
        PSELx   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        PSTRB   = strb;
        @(posedge PCLK);
        #1 PENABLE = 1'b1;
        @(negedge PCLK);
        if (chk) begin
            e = sb_q.pop_front();
            check({e.tag, ".rdata"}, PRDATA, e.rdata);
            check({e.tag, ".err"}, {31'b0, PSLVERR}, {31'b0, e.err});
        end
        @(posedge PCLK);
        #1;
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        apb(1'b1, addr, data, strb, 1'b0, 32'h0, 1'b0, "");
    endtask

    task automatic rd(input logic [7:0] addr, input logic [31:0] exp, input string tag);
        apb(1'b0, addr, 32'h0, 4'h0, 1'b1, exp, 1'b0, tag);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET  = 1'b1;
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        PSTRB   = '0;
        gpio_in = '0;
        cycles(2);
        PRESET = 1'b0;

        // Reset state; default config is level-low and pins are low, so status fills.
        check("rst.gpio_out", gpio_out, 32'h0);
        check("rst.gpio_oe", gpio_oe, 32'h0);
        check("rst.irq", {31'b0, irq}, 32'h0);
        check("rst.pready", {31'b0, PREADY}, 32'h1);
        check("rst.prdata_idle", PRDATA, 32'h0);
        check("rst.pslverr_idle", {31'b0, PSLVERR}, 32'h0);
        cycles(3);
        rd(8'h00, 32'h0, "t1.data_out");
        rd(8'h04, 32'h0, "t1.dir");
        rd(8'h08, 32'h0, "t1.data_in");
        rd(8'h0C, 32'h0, "t1.int_en");
        rd(8'h10, 32'h0, "t1.int_type");
        rd(8'h14, 32'h0, "t1.int_pol");
        rd(8'h18, 32'hFFFF_FFFF, "t1.int_status");
        rd(8'h1C, 32'h0, "t1.out_set");
        rd(8'h20, 32'h0, "t1.out_clr");
        check("t1.irq", {31'b0, irq}, 32'h0);

        // Byte strobes, atomic set/clear.
        wr(8'h04, 32'h0000_FFFF, 4'hF);
        check("t2.gpio_oe_same_edge", gpio_oe, 32'h0000_FFFF);
        wr(8'h00, 32'h1234_5678, 4'b0011);
        check("t2.gpio_out_same_edge", gpio_out, 32'h0000_5678);
        wr(8'h1C, 32'h0001_0000, 4'b0011);
        wr(8'h20, 32'h0000_0008, 4'b0011);
        rd(8'h00, 32'h0000_5670, "t2.data_out");
        check("t2.gpio_out", gpio_out, 32'h0000_5670);
        check("t2.gpio_oe", gpio_oe, 32'h0000_FFFF);
        wr(8'h1C, 32'h0001_0000, 4'hF);
        rd(8'h00, 32'h0001_5670, "t2.set_full");
        wr(8'h20, 32'h0001_0040, 4'hF);
        rd(8'h00, 32'h0000_5630, "t2.clr_full");
        wr(8'h00, 32'hFFFF_FFFF, 4'h0);
        rd(8'h00, 32'h0000_5630, "t2.zero_strobe");

        // Rising edge on pin 3 with latency check.
        wr(8'h14, 32'hFFFF_FFFF, 4'hF);
        wr(8'h10, 32'hFFFF_FFFF, 4'hF);
        wr(8'h18, 32'hFFFF_FFFF, 4'hF);
        wr(8'h0C, 32'h0000_0008, 4'hF);
        rd(8'h18, 32'h0, "t3.status_clear");
        check("t3.irq_idle", {31'b0, irq}, 32'h0);
        gpio_in[3] = 1'b1;
        @(posedge PCLK);
        @(posedge PCLK);
        @(posedge PCLK);
        @(negedge PCLK);
        check("t3.irq_before", {31'b0, irq}, 32'h0);
        @(posedge PCLK);
        @(negedge PCLK);
        check("t3.irq_edge3", {31'b0, irq}, 32'h1);
        @(posedge PCLK);
        #1;
        rd(8'h18, 32'h0000_0008, "t3.status");
        rd(8'h08, 32'h0000_0008, "t3.data_in");
        wr(8'h18, 32'h0000_0008, 4'hF);
        @(negedge PCLK);
        check("t3.irq_hold", {31'b0, irq}, 32'h1);
        @(posedge PCLK);
        @(negedge PCLK);
        check("t3.irq_drop", {31'b0, irq}, 32'h0);
        @(posedge PCLK);
        #1;
        rd(8'h18, 32'h0, "t3.status_w1c");

        // Level-low on pin 5; set wins over W1C while the level persists.
        wr(8'h10, 32'hFFFF_FFDF, 4'hF);
        wr(8'h14, 32'hFFFF_FFDF, 4'hF);
        rd(8'h18, 32'h0000_0020, "t4.status_level");
        wr(8'h18, 32'h0000_0020, 4'hF);
        rd(8'h18, 32'h0000_0020, "t4.set_wins");
        check("t4.irq_masked", {31'b0, irq}, 32'h0);
        gpio_in[5] = 1'b1;
        cycles(4);
        wr(8'h18, 32'h0000_0020, 4'hF);
        rd(8'h18, 32'h0, "t4.released");
        rd(8'h08, 32'h0000_0028, "t4.data_in");

        // Reset during a write's access phase; reset must win.
        PSELx   = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = 8'h04;
        PWDATA  = 32'hAAAA_AAAA;
        PSTRB   = 4'hF;
        gpio_in = 32'hFFFF_FFFF;
        @(posedge PCLK);
        #1;
        PENABLE = 1'b1;
        PRESET  = 1'b1;
        @(posedge PCLK);
        #1;
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        check("t5.gpio_oe", gpio_oe, 32'h0);
        check("t5.gpio_out", gpio_out, 32'h0);
        check("t5.irq", {31'b0, irq}, 32'h0);
        // Synchroniser restarts at 0, so level-low briefly sees every pin low.
        cycles(3);
        rd(8'h18, 32'hFFFF_FFFF, "t5.status_transient");
        rd(8'h08, 32'hFFFF_FFFF, "t5.data_in");
        wr(8'h14, 32'hFFFF_FFFF, 4'hF);
        wr(8'h10, 32'hFFFF_FFFF, 4'hF);
        wr(8'h18, 32'hFFFF_FFFF, 4'hF);
        cycles(6);
        rd(8'h18, 32'h0, "t5.no_edges");
        rd(8'h04, 32'h0, "t5.dir");

        // Error responses leave state untouched.
        wr(8'h00, 32'hA5A5_A5A5, 4'hF);
        apb(1'b0, 8'h24, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, "t6.rd_24");
        apb(1'b0, 8'h02, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, "t6.rd_02");
        apb(1'b1, 8'h08, 32'h1234_0000, 4'hF, 1'b1, 32'h0, 1'b1, "t6.wr_08");
        apb(1'b1, 8'h01, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 1'b1, "t6.wr_01");
        apb(1'b1, 8'h24, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1, "t6.wr_24");
        apb(1'b1, 8'h05, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 1'b1, "t6.wr_05");
        rd(8'h00, 32'hA5A5_A5A5, "t6.data_out");
        rd(8'h04, 32'h0, "t6.dir");
        check("t6.gpio_out", gpio_out, 32'hA5A5_A5A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
